mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage controller on the read side of the execute/memory pipeline latch. It consumes the latched memory-access fields, drives the data-cache request handshake, stalls the pipeline until `dhit`, and produces the load/store-conditional result for the memory/writeback latch. It also keeps the load-link reservation and latches `halt` once all memory traffic has drained.

## Interface
- `TIMEOUT_CYC`, 1023: number of consecutive wait cycles after which `mem_timeout` is set.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `m_valid` in 1: the latch holds a real instruction; 0 means bubble.
- `m_dREN`, `m_dWEN`, `m_datomic` in 1: latched load, store and atomic (LL/SC) flags.
- `m_halt` in 1: latched halt instruction.
- `m_port_o` in 32 (`word_t`): effective address.
- `m_memstore` in 32 (`word_t`): store data.
- `dhit` in 1: cache completed the current request this cycle.
- `dmemload` in 32 (`word_t`): cache read data, valid with `dhit`.
- `snoop_inv` in 1 and `snoop_addr` in 32: remote invalidation of a word address.
- `dmemREN`, `dmemWEN`, `datomic` out 1: cache request.
- `dmemaddr`, `dmemstore` out 32: request address and data; 0 when no request.
- `mem_stall` out 1: freeze fetch through execute and the execute/memory latch.
- `w_result` out 32: load data, or SC result (1 = success, 0 = fail).
- `halt_o` out 1: sticky halt.
- `mem_timeout` out 1: sticky watchdog flag.

## Operation
- The FSM has three states:
  - **IDLE**: if `m_valid` and (`m_dREN` or `m_dWEN`), a request is driven combinationally this cycle.
    - `dhit` in the same cycle: the access completes and the FSM stays in IDLE.
    - No `dhit`: the FSM goes to WAIT.
    - If `m_valid`, `m_halt` and no access: the FSM goes to HALTED.
  - **WAIT**: the request is held from the latch fields, which are frozen by `mem_stall`. On `dhit`, the FSM returns to IDLE.
  - **HALTED**: terminal until reset. All requests are 0, `mem_stall` = 1 and `halt_o` = 1.
- `mem_stall` = request active AND NOT `dhit`.
- `w_result` = `dmemload` for loads. For SC it is 1 or 0 as defined below. Otherwise it is 0.
- Load-link/store-conditional (LL/SC), when enabled:
  - **LL** (`dREN` & `datomic`): on `dhit`, set `link_valid` and capture `link_addr` = `m_port_o`.
  - **SC** (`dWEN` & `datomic`): the request is issued only while `link_valid` and `link_addr` == `m_port_o`.
    - On `dhit`: `w_result` = 1 and the link is cleared.
    - If the link is lost, either at issue or during WAIT: `dmemWEN` drops, `w_result` = 0, no stall, and the FSM returns to IDLE in that cycle.
  - A plain store from this core to `link_addr` clears the link when it completes.
  - `snoop_inv` with `snoop_addr` == `link_addr` clears the link.
- Watchdog:
  - A counter increments on each WAIT cycle and saturates at `TIMEOUT_CYC`.
  - At saturation, `mem_timeout` is set (sticky).
  - The counter resets to 0 when the FSM enters IDLE.
  - The request is never aborted by the watchdog.

## Timing
- Reset state: FSM in IDLE, `link_valid` = 0, `link_addr` = 0, counter = 0, `halt_o` = 0, `mem_timeout` = 0. While `nRST` is low, every output is 0.
- Latency: a hit completes in 0 wait cycles (same-cycle `dhit`). A miss completes in N stall cycles for a `dhit` N cycles later.
- Request outputs are stable from assertion until `dhit`; the cache may rely on this.
- Simultaneous events:
  - LL `dhit` and a matching `snoop_inv` in the same cycle: the link set wins.
  - SC check and a matching `snoop_inv` in the same cycle: the snoop wins and the SC fails.
- A `m_halt` with `m_valid` while in WAIT is not possible, because the latch is frozen.
- A reset asserted mid-WAIT returns the FSM to IDLE on that edge. The cache sees the request drop.

## Configuration
- `MEM_LLSC_EN` defined: link register, SC check and snoop clearing are present. `datomic` follows `m_datomic`.
- Not defined: `datomic` = 0, `snoop_*` are ignored, and no link state exists. LL behaves as a plain load. SC behaves as a plain store with `w_result` = 1 on `dhit`.

## Structure
- `cpu_types_pkg` gains `memctl_state_t` (IDLE, WAIT, HALTED) and `MEM_TIMEOUT_DEFAULT` = 1023.
- One sub-module, `llsc_link`: link register, address compare, set/clear priority. It is instantiated only under `MEM_LLSC_EN`.

## Test plan
- Load hit: LW at 0x100 with `dhit` in the same cycle and `dmemload` = 0xDEADBEEF -> `mem_stall` = 0 and `w_result` = 0xDEADBEEF.
- Store miss: SW at 0x200, data 0x5, `dhit` after 3 cycles -> `mem_stall` high for 3 cycles, `dmemWEN`/`dmemaddr`/`dmemstore` stable, then IDLE.
- LL/SC success and failure:
  - LL at 0x40, then SC at 0x40 -> `w_result` = 1 and the link is cleared.
  - Repeat with `snoop_inv` at 0x40 between them -> `dmemWEN` never asserted and `w_result` = 0.
- Halt: `m_halt` in IDLE -> `halt_o` = 1 next cycle, `mem_stall` = 1, later accesses produce no request.
- Watchdog: `TIMEOUT_CYC` = 4 and `dhit` withheld for 6 cycles -> `mem_timeout` rises after 4 wait cycles and remains set after `dhit`.
- Mid-operation reset: `nRST` low during WAIT -> all outputs 0 and FSM in IDLE. After release, an LW hit completes normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: data word and memory-stage controller state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HALTED
  } memctl_state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 1023;
endpackage

// File: rtl/llsc_link.sv
// Load-link reservation: one word address, set by a completed LL and cleared by
// a completed SC, a local plain store or a remote snoop to the same word.
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ll_done,
  input  logic  sc_done,
  input  logic  st_done,
  input  word_t acc_addr,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  output logic  link_match
);
  logic  link_valid;
  word_t link_addr;
  logic  snoop_hit;

  assign snoop_hit  = snoop_inv && (snoop_addr == link_addr);
  // A same-cycle snoop defeats the SC check even though the register still holds.
  assign link_match = link_valid && (link_addr == acc_addr) && !snoop_hit;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (ll_done) begin
      link_valid <= 1'b1;
      link_addr  <= acc_addr;
    end else if (sc_done || (st_done && acc_addr == link_addr) || snoop_hit) begin
      link_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: dcache handshake, stall until dhit, LL/SC result,
// sticky halt and watchdog. LL/SC reservation logic is built under MEM_LLSC_EN.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYC = MEM_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        m_valid,
  input  logic        m_dREN,
  input  logic        m_dWEN,
  input  logic        m_datomic,
  input  logic        m_halt,
  input  logic [31:0] m_port_o,
  input  logic [31:0] m_memstore,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        datomic,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] w_result,
  output logic        halt_o,
  output logic        mem_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

  memctl_state_t state;
  logic          halt_q, to_q;
  logic [CW-1:0] wd_cnt;
  logic          run, access, is_sc, sc_fail, req, done;

  assign run    = nRST && m_valid && (state != HALTED);
  assign access = m_dREN || m_dWEN;
  assign is_sc  = m_dWEN && m_datomic;

`ifdef MEM_LLSC_EN
  logic link_ok;

  llsc_link u_link (
    .CLK       (CLK),
    .nRST      (nRST),
    .ll_done   (done && m_dREN && m_datomic),
    .sc_done   (done && is_sc),
    .st_done   (done && m_dWEN && !m_datomic),
    .acc_addr  (m_port_o),
    .snoop_inv (snoop_inv),
    .snoop_addr(snoop_addr),
    .link_match(link_ok)
  );

  assign sc_fail = run && is_sc && !link_ok;
  assign datomic = req && m_datomic;
`else
  logic unused_snoop;
  assign unused_snoop = ^{snoop_inv, snoop_addr};
  assign sc_fail      = 1'b0;
  assign datomic      = 1'b0;
`endif

  // A failed SC never reaches the cache, so it neither stalls nor waits.
  assign req       = run && access && !sc_fail;
  assign done      = req && dhit;
  assign dmemREN   = req && m_dREN;
  assign dmemWEN   = req && m_dWEN;
  assign dmemaddr  = req ? m_port_o : '0;
  assign dmemstore = req ? m_memstore : '0;
  assign mem_stall = nRST && ((req && !dhit) || state == HALTED);
  assign halt_o      = nRST && halt_q;
  assign mem_timeout = nRST && to_q;

  always_comb begin
    w_result = '0;
    if (run && m_dREN)     w_result = dmemload;
    else if (run && is_sc) w_result = {31'b0, done};
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      halt_q <= 1'b0;
      to_q   <= 1'b0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (req && !dhit) state <= WAIT;
          else if (run && m_halt && !access) begin
            state  <= HALTED;
            halt_q <= 1'b1;
          end
        WAIT:
          if (!req || dhit) state <= IDLE;
        default: state <= HALTED;
      endcase
      // Counts wait cycles only; any exit from WAIT drops it back to zero.
      if (state == WAIT && req && !dhit) begin
        if (wd_cnt != TMAX) wd_cnt <= wd_cnt + CW'(1);
        if (wd_cnt == TMAX - CW'(1)) to_q <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end
endmodule
